// File: rtl/aq_axi_sdma64_pkg.sv
// ---------------------------------------------------------------------------
// aq_axi_sdma64_pkg
// Shared definitions for the 64-bit AXI slave memory model:
//   - AXI response codes used on BRESP / RRESP
//   - state encodings for the independent write and read channel FSMs
//   - helper that maps an address-window miss onto a response code
// ---------------------------------------------------------------------------
package aq_axi_sdma64_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wrState_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rdState_e;

    // A burst whose start address falls outside the decoded window is
    // answered with DECERR; everything else is OKAY.
    function automatic logic [1:0] respFor(input logic miss);
        return miss ? RESP_DECERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/aq_axi_sdma64_slvmem_ram.sv
// ---------------------------------------------------------------------------
// aq_axi_sdma64_slvmem_ram
// 64-bit wide storage array with one byte-enabled write port and one
// registered read port (1-cycle read latency).
//
// Ports:
//   clk_i, rst_i      clock / async active-high reset (read register only;
//                     the array contents are never cleared)
//   wrEn_i            write strobe
//   wrAddr_i          word address for the write
//   wrData_i          write data
//   wrStrb_i          per-byte write enables
//   rdEn_i            load the read register this cycle
//   rdAddr_i          word address for the read
//   rdData_o          registered read data, holds while rdEn_i is low
// ---------------------------------------------------------------------------
module aq_axi_sdma64_slvmem_ram #(
    parameter int WORD_AW = 13
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wrEn_i,
    input  logic [WORD_AW-1:0] wrAddr_i,
    input  logic [63:0]        wrData_i,
    input  logic [7:0]         wrStrb_i,
    input  logic               rdEn_i,
    input  logic [WORD_AW-1:0] rdAddr_i,
    output logic [63:0]        rdData_o
);

    logic [63:0] mem [0:(2**WORD_AW)-1];
    logic [63:0] rdData_q;

    // Byte-lane write; no reset so contents survive RST.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            for (int b = 0; b < 8; b++) begin
                if (wrStrb_i[b]) begin
                    mem[wrAddr_i][b*8 +: 8] <= wrData_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read. A same-cycle write to the same word is not yet
    // visible, so the old contents are returned.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/aq_axi_sdma64_slvmem.sv
// ---------------------------------------------------------------------------
// aq_axi_sdma64_slvmem
// AXI3/4-style 64-bit slave memory. INCR bursts of 8-byte beats only.
// Independent write (AW/W/B) and read (AR/R) state machines share one
// byte-enabled RAM.
//
// Parameters:
//   ADRS_W     byte-address bits decoded (memory is 2^ADRS_W bytes)
//   BASE_ADRS  window base; address bits above ADRS_W are compared for a hit
//
// Ports:
//   ACLK, RST                      clock / async active-high reset
//   S_AXI_AW*                      write address channel (ID, ADDR, LEN)
//   S_AXI_W*                       write data channel (DATA, STRB, LAST)
//   S_AXI_B*                       write response channel
//   S_AXI_AR*                      read address channel (ID, ADDR, LEN)
//   S_AXI_R*                       read data channel
//
// Configuration macro: AQ_AXI_SDMA64_SLVMEM_DECERR_EN
//   defined   - bursts starting outside the BASE_ADRS window get DECERR,
//               writes are dropped and read data is forced to zero
//   undefined - upper address bits are ignored (memory aliases), all OKAY
// ---------------------------------------------------------------------------
module aq_axi_sdma64_slvmem
    import aq_axi_sdma64_pkg::*;
#(
    parameter int          ADRS_W    = 16,
    parameter logic [31:0] BASE_ADRS = 32'h0000_0000
) (
    input  logic        ACLK,
    input  logic        RST,
    input  logic        S_AXI_AWID,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [7:0]  S_AXI_AWLEN,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [63:0] S_AXI_WDATA,
    input  logic [7:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WLAST,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic        S_AXI_BID,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic        S_AXI_ARID,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [7:0]  S_AXI_ARLEN,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic        S_AXI_RID,
    output logic [63:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RLAST,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int WORD_AW = ADRS_W - 3;

    // Write channel state
    wrState_e           wrState_q;
    logic [WORD_AW-1:0] wrPtr_q;
    logic [7:0]         wrLen_q;
    logic [8:0]         wrBeat_q;
    logic               wrId_q;
    logic               wrErr_q;
    logic               awReady_q;
    logic               wReady_q;
    logic               bValid_q;
    logic               bId_q;
    logic [1:0]         bResp_q;

    // Read channel state
    rdState_e           rdState_q;
    logic [WORD_AW-1:0] rdPtr_q;
    logic [7:0]         rdLen_q;
    logic [8:0]         rdBeat_q;
    logic               rdErr_q;
    logic               arReady_q;
    logic               rValid_q;
    logic               rLast_q;
    logic               rId_q;
    logic [1:0]         rResp_q;

    // RAM hookup
    logic               ramWrEn_d;
    logic               ramRdEn_d;
    logic [63:0]        ramRdData;

    logic               awMiss;
    logic               arMiss;
    logic               unusedBits;

`ifdef AQ_AXI_SDMA64_SLVMEM_DECERR_EN
    assign awMiss = (S_AXI_AWADDR[31:ADRS_W] != BASE_ADRS[31:ADRS_W]);
    assign arMiss = (S_AXI_ARADDR[31:ADRS_W] != BASE_ADRS[31:ADRS_W]);
`else
    assign awMiss = 1'b0;
    assign arMiss = 1'b0;
`endif

    // Beat alignment bits and WLAST carry no information here: the burst
    // length alone decides where a write burst ends.
    assign unusedBits = ^{S_AXI_WLAST, S_AXI_AWADDR[2:0], S_AXI_ARADDR[2:0],
                          S_AXI_AWADDR[31:ADRS_W], S_AXI_ARADDR[31:ADRS_W],
                          BASE_ADRS};

    // Only beats of a burst that hit the window reach the array.
    assign ramWrEn_d = (wrState_q == W_DATA) & S_AXI_WVALID & ~wrErr_q;

    // Read the first word in R_ADDR, then prefetch the next word whenever
    // a non-final beat is accepted so the following cycle already has it.
    assign ramRdEn_d = (rdState_q == R_ADDR) |
                       ((rdState_q == R_DATA) & S_AXI_RREADY & ~rLast_q);

    aq_axi_sdma64_slvmem_ram #(
        .WORD_AW (WORD_AW)
    ) u_ram (
        .clk_i    (ACLK),
        .rst_i    (RST),
        .wrEn_i   (ramWrEn_d),
        .wrAddr_i (wrPtr_q),
        .wrData_i (S_AXI_WDATA),
        .wrStrb_i (S_AXI_WSTRB),
        .rdEn_i   (ramRdEn_d),
        .rdAddr_i (rdPtr_q),
        .rdData_o (ramRdData)
    );

    // Write FSM: accept AW, count W beats up to AWLEN, then hold B until
    // the master takes it. Word pointer wraps inside the memory.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            wrState_q <= W_IDLE;
            wrPtr_q   <= '0;
            wrLen_q   <= '0;
            wrBeat_q  <= '0;
            wrId_q    <= 1'b0;
            wrErr_q   <= 1'b0;
            awReady_q <= 1'b1;
            wReady_q  <= 1'b0;
            bValid_q  <= 1'b0;
            bId_q     <= 1'b0;
            bResp_q   <= RESP_OKAY;
        end else begin
            case (wrState_q)
                W_IDLE: begin
                    if (S_AXI_AWVALID) begin
                        wrId_q    <= S_AXI_AWID;
                        wrPtr_q   <= S_AXI_AWADDR[ADRS_W-1:3];
                        wrLen_q   <= S_AXI_AWLEN;
                        wrBeat_q  <= '0;
                        wrErr_q   <= awMiss;
                        awReady_q <= 1'b0;
                        wReady_q  <= 1'b1;
                        wrState_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (S_AXI_WVALID) begin
                        wrPtr_q  <= wrPtr_q + WORD_AW'(1);
                        wrBeat_q <= wrBeat_q + 9'd1;
                        if (wrBeat_q == {1'b0, wrLen_q}) begin
                            wReady_q  <= 1'b0;
                            bValid_q  <= 1'b1;
                            bId_q     <= wrId_q;
                            bResp_q   <= respFor(wrErr_q);
                            wrState_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bValid_q  <= 1'b0;
                        awReady_q <= 1'b1;
                        wrState_q <= W_IDLE;
                    end
                end
                default: begin
                    wrState_q <= W_IDLE;
                    awReady_q <= 1'b1;
                    wReady_q  <= 1'b0;
                    bValid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: accept AR, spend one cycle issuing the first RAM read,
    // then stream beats. RLAST is precomputed so it is registered.
    always_ff @(posedge ACLK or posedge RST) begin
        if (RST) begin
            rdState_q <= R_IDLE;
            rdPtr_q   <= '0;
            rdLen_q   <= '0;
            rdBeat_q  <= '0;
            rdErr_q   <= 1'b0;
            arReady_q <= 1'b1;
            rValid_q  <= 1'b0;
            rLast_q   <= 1'b0;
            rId_q     <= 1'b0;
            rResp_q   <= RESP_OKAY;
        end else begin
            case (rdState_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        rdPtr_q   <= S_AXI_ARADDR[ADRS_W-1:3];
                        rdLen_q   <= S_AXI_ARLEN;
                        rdErr_q   <= arMiss;
                        rId_q     <= S_AXI_ARID;
                        rResp_q   <= respFor(arMiss);
                        arReady_q <= 1'b0;
                        rdState_q <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    rdPtr_q   <= rdPtr_q + WORD_AW'(1);
                    rdBeat_q  <= '0;
                    rValid_q  <= 1'b1;
                    rLast_q   <= (rdLen_q == 8'd0);
                    rdState_q <= R_DATA;
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rLast_q) begin
                            rValid_q  <= 1'b0;
                            rLast_q   <= 1'b0;
                            arReady_q <= 1'b1;
                            rdState_q <= R_IDLE;
                        end else begin
                            rdPtr_q  <= rdPtr_q + WORD_AW'(1);
                            rdBeat_q <= rdBeat_q + 9'd1;
                            rLast_q  <= ((rdBeat_q + 9'd1) == {1'b0, rdLen_q});
                        end
                    end
                end
                default: begin
                    rdState_q <= R_IDLE;
                    arReady_q <= 1'b1;
                    rValid_q  <= 1'b0;
                    rLast_q   <= 1'b0;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awReady_q;
    assign S_AXI_WREADY  = wReady_q;
    assign S_AXI_BVALID  = bValid_q;
    assign S_AXI_BID     = bId_q;
    assign S_AXI_BRESP   = bResp_q;
    assign S_AXI_ARREADY = arReady_q;
    assign S_AXI_RVALID  = rValid_q;
    assign S_AXI_RLAST   = rLast_q;
    assign S_AXI_RID     = rId_q;
    assign S_AXI_RRESP   = rResp_q;
    assign S_AXI_RDATA   = rdErr_q ? 64'd0 : ramRdData;

endmodule

// File: tb/tb_aq_axi_sdma64_slvmem.sv
// ---------------------------------------------------------------------------
// tb_aq_axi_sdma64_slvmem
// Directed testbench for the 64-bit AXI slave memory. Each scenario task
// drives its own bursts and compares against hand-computed values.
// Honours AQ_AXI_SDMA64_SLVMEM_DECERR_EN for the address-decode scenario.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aq_axi_sdma64_slvmem;

    logic        ACLK;
    logic        RST;
    logic        AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic        BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic        ARID;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic        ARVALID;
    logic        ARREADY;
    logic        RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int vecCount  = 0;
    int missCount = 0;

    // Write driver results
    logic [63:0] wBeats [256];
    logic        wrTimeout;
    logic        bDropped;
    logic        bIdSeen;
    logic [1:0]  bRespSeen;

    // Read collector results
    logic [63:0] rData [256];
    logic        rLastSeen [256];
    logic [1:0]  rRespSeen [256];
    logic        rIdSeen;
    int          rCount;
    int          stallViol;
    logic        rdTimeout;

    aq_axi_sdma64_slvmem #(
        .ADRS_W    (16),
        .BASE_ADRS (32'h0000_0000)
    ) dut (
        .ACLK          (ACLK),
        .RST           (RST),
        .S_AXI_AWID    (AWID),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWLEN   (AWLEN),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WLAST   (WLAST),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BID     (BID),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARID    (ARID),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARLEN   (ARLEN),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RID     (RID),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RLAST   (RLAST),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY)
    );

    // 100 MHz clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Data pattern used for the long read burst
    function automatic logic [63:0] longPat(input int i);
        return {16'hC0DE, 16'(i), 32'(i * 7 + 3)};
    endfunction

    // Drive one write burst from wBeats[], then collect the B response.
    // earlyLast raises WLAST on the first beat instead of the final one.
    task automatic doWrite(input logic [31:0] addr, input logic [7:0] len,
                           input logic id, input logic [7:0] strb,
                           input int bDelay, input bit earlyLast);
        int cyc;
        wrTimeout = 1'b0;
        bDropped  = 1'b0;
        AWADDR = addr; AWLEN = len; AWID = id; AWVALID = 1'b1;
        cyc = 0;
        while (!AWREADY && cyc < 300) begin @(posedge ACLK); #1; cyc++; end
        if (cyc >= 300) wrTimeout = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            WDATA = wBeats[i];
            WSTRB = strb;
            WLAST = earlyLast ? (i == 0) : (i == int'(len));
            WVALID = 1'b1;
            cyc = 0;
            while (!WREADY && cyc < 300) begin @(posedge ACLK); #1; cyc++; end
            if (cyc >= 300) wrTimeout = 1'b1;
            @(posedge ACLK); #1;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        cyc = 0;
        while (!BVALID && cyc < 300) begin @(posedge ACLK); #1; cyc++; end
        if (cyc >= 300) wrTimeout = 1'b1;
        bIdSeen   = BID;
        bRespSeen = BRESP;
        for (int d = 0; d < bDelay; d++) begin
            @(posedge ACLK); #1;
            if (!BVALID) bDropped = 1'b1;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    // Issue one read burst and record every accepted beat. With toggle set
    // RREADY alternates 1/0; RDATA must not move while a beat is stalled.
    task automatic doRead(input logic [31:0] addr, input logic [7:0] len,
                          input logic id, input bit toggle);
        int   cyc;
        bit   done;
        bit   haveStall;
        logic [63:0] stallData;
        rCount    = 0;
        stallViol = 0;
        rdTimeout = 1'b0;
        done      = 1'b0;
        haveStall = 1'b0;
        stallData = '0;
        ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1;
        cyc = 0;
        while (!ARREADY && cyc < 300) begin @(posedge ACLK); #1; cyc++; end
        if (cyc >= 300) rdTimeout = 1'b1;
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (RVALID && haveStall && (RDATA !== stallData)) stallViol++;
            if (RVALID && RREADY) begin
                if (rCount < 256) begin
                    rData[rCount]     = RDATA;
                    rLastSeen[rCount] = RLAST;
                    rRespSeen[rCount] = RRESP;
                end
                rIdSeen   = RID;
                rCount++;
                haveStall = 1'b0;
                if (RLAST) done = 1'b1;
            end else if (RVALID) begin
                haveStall = 1'b1;
                stallData = RDATA;
            end
            @(posedge ACLK); #1;
            cyc++;
            if (toggle) RREADY = ~RREADY;
        end
        RREADY = 1'b0;
        if (!done) rdTimeout = 1'b1;
    endtask

    // Outputs held and released in reset
    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        vecCount++; if (AWREADY !== 1'b1) begin missCount++; $display("[TB] FAIL reset_awready: got %b expected 1", AWREADY); end
        vecCount++; if (ARREADY !== 1'b1) begin missCount++; $display("[TB] FAIL reset_arready: got %b expected 1", ARREADY); end
        vecCount++; if (WREADY !== 1'b0) begin missCount++; $display("[TB] FAIL reset_wready: got %b expected 0", WREADY); end
        vecCount++; if (BVALID !== 1'b0) begin missCount++; $display("[TB] FAIL reset_bvalid: got %b expected 0", BVALID); end
        vecCount++; if (RVALID !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rvalid: got %b expected 0", RVALID); end
        vecCount++; if (RLAST !== 1'b0) begin missCount++; $display("[TB] FAIL reset_rlast: got %b expected 0", RLAST); end
        vecCount++; if ({BRESP, RRESP} !== 4'b0000) begin missCount++; $display("[TB] FAIL reset_resp: got %b expected 0000", {BRESP, RRESP}); end
        vecCount++; if ({BID, RID} !== 2'b00) begin missCount++; $display("[TB] FAIL reset_ids: got %b expected 00", {BID, RID}); end
        vecCount++; if (RDATA !== 64'd0) begin missCount++; $display("[TB] FAIL reset_rdata: got %h expected 0", RDATA); end
        RST = 1'b0;
        @(posedge ACLK); #1;
        vecCount++; if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin missCount++; $display("[TB] FAIL post_reset_ready: got aw=%b ar=%b expected 1/1", AWREADY, ARREADY); end
    endtask

    // 4-beat write then read back at 0x100
    task automatic test_basic_burst();
        wBeats[0] = 64'h11; wBeats[1] = 64'h22; wBeats[2] = 64'h33; wBeats[3] = 64'h44;
        doWrite(32'h100, 8'd3, 1'b1, 8'hFF, 0, 1'b0);
        vecCount++; if (wrTimeout !== 1'b0) begin missCount++; $display("[TB] FAIL basic_wr_timeout: got %b expected 0", wrTimeout); end
        vecCount++; if (bRespSeen !== 2'b00) begin missCount++; $display("[TB] FAIL basic_bresp: got %b expected 00", bRespSeen); end
        vecCount++; if (bIdSeen !== 1'b1) begin missCount++; $display("[TB] FAIL basic_bid: got %b expected 1", bIdSeen); end
        doRead(32'h100, 8'd3, 1'b1, 1'b0);
        vecCount++; if (rdTimeout !== 1'b0 || rCount != 4) begin missCount++; $display("[TB] FAIL basic_rd_count: got %0d beats timeout=%b expected 4 beats", rCount, rdTimeout); end
        for (int i = 0; i < 4; i++) begin
            vecCount++;
            if (rData[i] !== 64'(8'h11 * (i + 1)) || rLastSeen[i] !== (i == 3) || rRespSeen[i] !== 2'b00) begin
                missCount++;
                $display("[TB] FAIL basic_beat%0d: got data=%h last=%b resp=%b expected data=%h last=%b resp=00",
                         i, rData[i], rLastSeen[i], rRespSeen[i], 64'(8'h11 * (i + 1)), (i == 3));
            end
        end
        vecCount++; if (rIdSeen !== 1'b1) begin missCount++; $display("[TB] FAIL basic_rid: got %b expected 1", rIdSeen); end
    endtask

    // Byte strobes only touch enabled lanes
    task automatic test_strobe();
        wBeats[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        doWrite(32'h200, 8'd0, 1'b0, 8'hFF, 0, 1'b0);
        wBeats[0] = 64'h0;
        doWrite(32'h200, 8'd0, 1'b0, 8'h0F, 0, 1'b0);
        doRead(32'h200, 8'd0, 1'b0, 1'b0);
        vecCount++; if (rCount != 1 || rData[0] !== 64'hFFFF_FFFF_0000_0000) begin missCount++; $display("[TB] FAIL strobe_data: got %h (%0d beats) expected ffffffff00000000", rData[0], rCount); end
        vecCount++; if (rLastSeen[0] !== 1'b1) begin missCount++; $display("[TB] FAIL strobe_rlast: got %b expected 1", rLastSeen[0]); end
    endtask

    // Early WLAST on the write, RREADY toggling on the read
    task automatic test_rready_toggle();
        for (int i = 0; i < 8; i++) wBeats[i] = 64'h5000_0000_0000_0000 + 64'(i * 257);
        doWrite(32'h500, 8'd7, 1'b0, 8'hFF, 0, 1'b1);
        vecCount++; if (wrTimeout !== 1'b0 || bRespSeen !== 2'b00) begin missCount++; $display("[TB] FAIL earlylast_write: got timeout=%b bresp=%b expected 0/00", wrTimeout, bRespSeen); end
        doRead(32'h500, 8'd7, 1'b0, 1'b1);
        vecCount++; if (rdTimeout !== 1'b0 || rCount != 8) begin missCount++; $display("[TB] FAIL toggle_count: got %0d beats timeout=%b expected 8", rCount, rdTimeout); end
        vecCount++; if (stallViol != 0) begin missCount++; $display("[TB] FAIL toggle_stall: got %0d rdata changes during stall expected 0", stallViol); end
        for (int i = 0; i < 8; i++) begin
            vecCount++;
            if (rData[i] !== 64'h5000_0000_0000_0000 + 64'(i * 257) || rLastSeen[i] !== (i == 7)) begin
                missCount++;
                $display("[TB] FAIL toggle_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         i, rData[i], rLastSeen[i], 64'h5000_0000_0000_0000 + 64'(i * 257), (i == 7));
            end
        end
    endtask

    // 256-beat read concurrent with a write whose BREADY comes 5 cycles late
    task automatic test_concurrent();
        for (int i = 0; i < 256; i++) wBeats[i] = longPat(i);
        doWrite(32'h400, 8'd255, 1'b0, 8'hFF, 0, 1'b0);
        vecCount++; if (wrTimeout !== 1'b0) begin missCount++; $display("[TB] FAIL long_prefill_timeout: got %b expected 0", wrTimeout); end
        for (int i = 0; i < 8; i++) wBeats[i] = 64'h3000 + 64'(i);
        fork
            doWrite(32'h300, 8'd7, 1'b1, 8'hFF, 5, 1'b0);
            doRead(32'h400, 8'd255, 1'b0, 1'b0);
        join
        vecCount++; if (rdTimeout !== 1'b0 || rCount != 256) begin missCount++; $display("[TB] FAIL conc_rd_count: got %0d beats timeout=%b expected 256", rCount, rdTimeout); end
        vecCount++; if (wrTimeout !== 1'b0 || bRespSeen !== 2'b00 || bIdSeen !== 1'b1) begin missCount++; $display("[TB] FAIL conc_wr_resp: got timeout=%b bresp=%b bid=%b expected 0/00/1", wrTimeout, bRespSeen, bIdSeen); end
        vecCount++; if (bDropped !== 1'b0) begin missCount++; $display("[TB] FAIL conc_bvalid_hold: got dropped=%b expected 0", bDropped); end
        for (int i = 0; i < 256; i++) begin
            vecCount++;
            if (rData[i] !== longPat(i) || rLastSeen[i] !== (i == 255)) begin
                missCount++;
                $display("[TB] FAIL conc_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         i, rData[i], rLastSeen[i], longPat(i), (i == 255));
            end
        end
        doRead(32'h300, 8'd7, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vecCount++;
            if (rData[i] !== 64'h3000 + 64'(i)) begin
                missCount++;
                $display("[TB] FAIL conc_wrback%0d: got %h expected %h", i, rData[i], 64'h3000 + 64'(i));
            end
        end
    endtask

    // Reset on beat 2 of a 4-beat write abandons it silently
    task automatic test_reset_midburst();
        bit sawB;
        AWADDR = 32'h600; AWLEN = 8'd3; AWID = 1'b1; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WSTRB = 8'hFF; WVALID = 1'b1;
        WDATA = 64'hA0; @(posedge ACLK); #1;
        WDATA = 64'hA1; @(posedge ACLK); #1;
        WDATA = 64'hA2;
        RST = 1'b1;
        #2;
        WVALID = 1'b0;
        @(posedge ACLK); #1;
        RST = 1'b0;
        @(posedge ACLK); #1;
        vecCount++; if (AWREADY !== 1'b1) begin missCount++; $display("[TB] FAIL midrst_awready: got %b expected 1", AWREADY); end
        vecCount++; if (WREADY !== 1'b0) begin missCount++; $display("[TB] FAIL midrst_wready: got %b expected 0", WREADY); end
        BREADY = 1'b1;
        sawB = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (BVALID) sawB = 1'b1;
            @(posedge ACLK); #1;
        end
        BREADY = 1'b0;
        vecCount++; if (sawB !== 1'b0) begin missCount++; $display("[TB] FAIL midrst_bvalid: got %b expected 0", sawB); end
    endtask

    // Read above the window: DECERR with zero data, or aliasing onto word 0/1
    task automatic test_decode();
        logic [1:0]  expResp;
        logic [63:0] expD0;
        logic [63:0] expD1;
        wBeats[0] = 64'hDEAD_BEEF_0123_4567;
        wBeats[1] = 64'h89AB_CDEF_FEDC_BA98;
        doWrite(32'h0, 8'd1, 1'b0, 8'hFF, 0, 1'b0);
`ifdef AQ_AXI_SDMA64_SLVMEM_DECERR_EN
        expResp = 2'b11; expD0 = 64'd0; expD1 = 64'd0;
`else
        expResp = 2'b00; expD0 = 64'hDEAD_BEEF_0123_4567; expD1 = 64'h89AB_CDEF_FEDC_BA98;
`endif
        doRead(32'h0001_0000, 8'd1, 1'b1, 1'b0);
        vecCount++; if (rdTimeout !== 1'b0 || rCount != 2) begin missCount++; $display("[TB] FAIL decode_count: got %0d beats timeout=%b expected 2", rCount, rdTimeout); end
        vecCount++; if (rRespSeen[0] !== expResp || rRespSeen[1] !== expResp) begin missCount++; $display("[TB] FAIL decode_rresp: got %b/%b expected %b", rRespSeen[0], rRespSeen[1], expResp); end
        vecCount++; if (rData[0] !== expD0 || rData[1] !== expD1) begin missCount++; $display("[TB] FAIL decode_rdata: got %h/%h expected %h/%h", rData[0], rData[1], expD0, expD1); end
        vecCount++; if (rLastSeen[1] !== 1'b1 || rIdSeen !== 1'b1) begin missCount++; $display("[TB] FAIL decode_last_id: got last=%b id=%b expected 1/1", rLastSeen[1], rIdSeen); end
    endtask

    initial begin
        RST = 1'b1;
        AWID = 1'b0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        BREADY = 1'b0;
        ARID = 1'b0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        test_reset();
        test_basic_burst();
        test_strobe();
        test_rready_toggle();
        test_concurrent();
        test_reset_midburst();
        test_decode();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/aq_axi_sdma64_slvmem.md
AQ_AXI_SDMA64_SLVMEM -- requirements
Module: aq_axi_sdma64_slvmem

Interface
REQ-001 SHALL have parameter ADRS_W, default 16, meaning byte-address bits decoded (memory = 2^ADRS_W bytes).
REQ-002 SHALL have parameter BASE_ADRS, default 32'h0000_0000, meaning window base; bits above ADRS_W compared for hit.
REQ-003 ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 S_AXI_AWID  in  1  write ID.
REQ-006 S_AXI_AWADDR  in  32  burst start byte address (8-byte aligned).
REQ-007 S_AXI_AWLEN  in  8  beats minus one.
REQ-008 S_AXI_AWVALID  in  1  / S_AXI_AWREADY  out  1  AW handshake.
REQ-009 S_AXI_WDATA  in  64  write data.
REQ-010 S_AXI_WSTRB  in  8  byte enables.
REQ-011 S_AXI_WLAST  in  1  final beat marker.
REQ-012 S_AXI_WVALID  in  1  / S_AXI_WREADY  out  1  W handshake.
REQ-013 S_AXI_BID  out  1  / S_AXI_BRESP  out  2  write response ID and code.
REQ-014 S_AXI_BVALID  out  1  / S_AXI_BREADY  in  1  B handshake.
REQ-015 S_AXI_ARID  in  1  / S_AXI_ARADDR  in  32  / S_AXI_ARLEN  in  8  read request.
REQ-016 S_AXI_ARVALID  in  1  / S_AXI_ARREADY  out  1  AR handshake.
REQ-017 S_AXI_RID  out  1  / S_AXI_RDATA  out  64  / S_AXI_RRESP  out  2  / S_AXI_RLAST  out  1  read beat.
REQ-018 S_AXI_RVALID  out  1  / S_AXI_RREADY  in  1  R handshake.

Function
REQ-019 Bursts SHALL be treated as INCR, size 8 bytes; AWSIZE/AWBURST/ARSIZE/ARBURST/cache/prot/QoS are not ports.
REQ-020 Write FSM SHALL be W_IDLE -> W_DATA (on AW handshake: latch ID, addr, len) -> W_RESP (on W handshake with beat count = len) -> W_IDLE (on BVALID&BREADY).
REQ-021 AWREADY SHALL be 1 only in W_IDLE; WREADY 1 only in W_DATA; BVALID 1 only in W_RESP, held until BREADY.
REQ-022 Each accepted W beat SHALL write bytes where WSTRB=1 at word (addr>>3)+beat; address wraps modulo 2^ADRS_W.
REQ-023 WLAST early or late vs. AWLEN SHALL be ignored; beat counter alone ends the burst; BRESP=OKAY unless REQ-031.
REQ-024 Read FSM SHALL be R_IDLE -> R_ADDR (AR handshake, issue RAM read, 1 cycle) -> R_DATA -> R_IDLE after beat with RLAST accepted.
REQ-025 RAM read latency SHALL be 1 cycle; RDATA held stable while RVALID&~RREADY; next word prefetched so back-to-back beats sustain 1 beat/cycle.
REQ-026 RLAST SHALL be 1 exactly on beat ARLEN; RID = latched ARID; RRESP=OKAY unless REQ-031.
REQ-027 Read and write FSMs SHALL run concurrently; same-cycle write and read of one word SHALL return old data.
REQ-028 AWLEN/ARLEN=255 SHALL yield 256 beats; 9-bit beat counters.

Reset
REQ-029 On RST: both FSMs idle, AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP/RRESP=0, BID/RID=0, RDATA=0; memory contents not cleared.
REQ-030 RST mid-burst SHALL abandon the burst immediately; no response issued afterward.

Configuration
REQ-031 With AQ_AXI_SDMA64_SLVMEM_DECERR_EN defined, a burst whose start address misses BASE_ADRS window SHALL get BRESP/RRESP=2'b11 (DECERR), writes suppressed, RDATA=0; without it, upper bits ignored and every access is OKAY (aliasing).

Structure
REQ-032 Package aq_axi_sdma64_pkg SHALL hold RESP_OKAY/RESP_DECERR constants and write/read FSM state typedefs.
REQ-033 Storage SHALL be sub-module aq_axi_sdma64_slvmem_ram: one write port with 8-bit byte enable, one registered read port.

Verification
REQ-034 AW addr 0x100 len 3, 4 beats 0x11..0x44, WSTRB=FF -> BRESP=0, BID echoed; AR 0x100 len 3 -> 0x11,0x22,0x33,0x44, RLAST on 4th.
REQ-035 Write 0xFFFF_FFFF_FFFF_FFFF then WSTRB=0x0F data 0 to 0x200 -> read 0xFFFF_FFFF_0000_0000.
REQ-036 Read len 7 with RREADY toggled 1/0 each cycle -> 8 beats, no duplicate/lost data, RDATA stable during stalls.
REQ-037 Concurrent write burst 0x300 and read burst 0x400 len 255 -> both complete, 256 read beats, BVALID held until BREADY asserted 5 cycles late.
REQ-038 RST asserted at write beat 2 of 4 -> BVALID never asserts, AWREADY=1 after release.
REQ-039 DECERR_EN defined, AR at BASE_ADRS+2^ADRS_W -> RRESP=3 all beats, RDATA=0; undefined -> RRESP=0, aliased data.
